op_elec_angle: RTL and testbench



---
 rtl/op_elec_angle.sv | 113 +++++++++++
 tb/tb_op_elec_angle.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/op_elec_angle.sv
// Encoder position to IEEE-754 single electrical angle in [0, 2*pi).
// Multi-cycle start/done op: diff, pole-pair scale, normalise, multiply by 2*pi, pack.
module op_elec_angle #(
  parameter int unsigned ENC_BITS = 14
) (
  input  logic                c,
  input  logic                rst,
  input  logic [ENC_BITS-1:0] pos,
  input  logic [ENC_BITS-1:0] offset,
  input  logic [3:0]          pp,
  input  logic                start,
  output logic [31:0]         q,
  output logic                done,
  output logic                busy
);

  localparam int unsigned MANT_BITS = 24;
  localparam int unsigned PROD_BITS = 2 * MANT_BITS;
  localparam logic [MANT_BITS-1:0] TWO_PI_MANT = 24'hC90FDB;

  typedef enum logic [2:0] {
    IDLE,
    DIFF,
    SCALE,
    NORM,
    MUL,
    PACK
  } state_t;

  state_t                 state;
  logic [ENC_BITS-1:0]    pos_r;
  logic [ENC_BITS-1:0]    off_r;
  logic [3:0]             pp_r;
  logic [ENC_BITS-1:0]    d;
  logic [MANT_BITS-1:0]   m;
  logic [4:0]             s;

  logic [ENC_BITS-1:0]    e_c;
  logic [PROD_BITS-1:0]   p_c;
  logic [22:0]            frac_c;
  logic [7:0]             exp_c;
  logic                   unused_low_c;

  // Pole-pair scaling; the product width naturally wraps mod 2^N.
  assign e_c = d * ENC_BITS'(pp_r);

  // Normalised mantissa times 2*pi mantissa; bits below the kept fraction are truncated.
  assign p_c          = PROD_BITS'(m) * PROD_BITS'(TWO_PI_MANT);
  assign unused_low_c = ^p_c[22:0];
  assign frac_c       = p_c[47] ? p_c[46:24] : p_c[45:23];
  // Biased exponent = (23 - s) - N + 2 + P[47] + 127.
  assign exp_c = 8'(10'd152 + 10'(p_c[47]) - 10'(ENC_BITS) - 10'(s));

  always_ff @(posedge c) begin
    if (rst) begin
      state <= IDLE;
      q     <= 32'h0000_0000;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pos_r <= pos;
            off_r <= offset;
            pp_r  <= pp;
            busy  <= 1'b1;
            state <= DIFF;
          end
        end
        DIFF: begin
          d     <= pos_r - off_r;
          state <= SCALE;
        end
        SCALE: begin
          if (e_c == '0) begin
            q     <= 32'h0000_0000;
            done  <= 1'b1;
            state <= PACK;
          end else begin
            m     <= MANT_BITS'(e_c);
            s     <= 5'd0;
            state <= NORM;
          end
        end
        NORM: begin
          if (!m[23]) begin
            m <= m << 1;
            s <= s + 5'd1;
          end else begin
            state <= MUL;
          end
        end
        MUL: begin
          // Product and pack land together so q and done are visible in the PACK cycle.
          q     <= {1'b0, exp_c, frac_c};
          done  <= 1'b1;
          state <= PACK;
        end
        PACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_elec_angle.sv
// Directed bench for op_elec_angle (ENC_BITS=14): values, latency, handshake, reset abort.
module tb_op_elec_angle;

  logic        c = 1'b0;
  logic        rst;
  logic [13:0] pos;
  logic [13:0] offset;
  logic [3:0]  pp;
  logic        start;
  logic [31:0] q;
  logic        done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  op_elec_angle #(.ENC_BITS(14)) dut (
    .c      (c),
    .rst    (rst),
    .pos    (pos),
    .offset (offset),
    .pp     (pp),
    .start  (start),
    .q      (q),
    .done   (done),
    .busy   (busy)
  );

  always #5 c = ~c;

  // Called mid-cycle (cycle 0); returns mid-cycle of cycle 1.
  task automatic launch(input logic [13:0] p, input logic [13:0] o, input logic [3:0] k);
    pos    = p;
    offset = o;
    pp     = k;
    start  = 1'b1;
    @(posedge c); #1;
    start  = 1'b0;
  endtask

  // Steps cycles starting at cycle 'first' until done; lat = -1 on timeout.
  task automatic wait_done(input int first, output int lat);
    bit seen = 0;
    lat = -1;
    for (int i = first; i < first + 40; i++) begin
      if (!seen && done) begin
        lat  = i;
        seen = 1;
      end
      if (!seen) begin
        @(posedge c); #1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; pos = '0; offset = '0; pp = '0;
    repeat (3) @(posedge c);
    #1;
    n_checks++;
    if (q !== 32'h0) begin n_fail++; $display("FAIL reset_q got=%h exp=%h", q, 32'h0); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(posedge c); #1;
  endtask

  task automatic test_pi;
    int lat;
    launch(14'h2000, 14'h0000, 4'd1);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL pi_busy_c1 got=%b exp=1", busy); end
    wait_done(1, lat);
    n_checks++;
    if (lat != 15) begin n_fail++; $display("FAIL pi_latency got=%0d exp=15", lat); end
    n_checks++;
    if (q !== 32'h40490FDB) begin n_fail++; $display("FAIL pi_q got=%h exp=40490fdb", q); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL pi_busy_pack got=%b exp=1", busy); end
    @(posedge c); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL pi_after busy=%b done=%b exp busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_zero;
    int lat;
    launch(14'h1234, 14'h1234, 4'd5);
    wait_done(1, lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL zero_diff_latency got=%0d exp=3", lat); end
    n_checks++;
    if (q !== 32'h0) begin n_fail++; $display("FAIL zero_diff_q got=%h exp=00000000", q); end
    @(posedge c); #1;
    launch(14'h0800, 14'h0000, 4'd0);
    wait_done(1, lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL zero_pp_latency got=%0d exp=3", lat); end
    n_checks++;
    if (q !== 32'h0) begin n_fail++; $display("FAIL zero_pp_q got=%h exp=00000000", q); end
    @(posedge c); #1;
  endtask

  task automatic test_wrap;
    int lat;
    launch(14'h0100, 14'h3F00, 4'd1);
    wait_done(1, lat);
    n_checks++;
    if (lat != 19) begin n_fail++; $display("FAIL wrap_latency got=%0d exp=19", lat); end
    n_checks++;
    if (q !== 32'h3E490FDB) begin n_fail++; $display("FAIL wrap_q got=%h exp=3e490fdb", q); end
    @(posedge c); #1;
  endtask

  task automatic test_pole_pairs;
    int lat;
    launch(14'h0800, 14'h0000, 4'd7);
    wait_done(1, lat);
    n_checks++;
    if (lat != 15) begin n_fail++; $display("FAIL pp7_latency got=%0d exp=15", lat); end
    n_checks++;
    if (q !== 32'h40AFEDDF) begin n_fail++; $display("FAIL pp7_q got=%h exp=40afeddf", q); end
    @(posedge c); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    launch(14'h2000, 14'h0000, 4'd1);
    repeat (4) @(posedge c);
    #1;
    // Cycle 5: stray start with a different operand must be ignored.
    pos = 14'h0001; pp = 4'd3; start = 1'b1;
    @(posedge c); #1;
    start = 1'b0;
    wait_done(6, lat);
    n_checks++;
    if (lat != 15) begin n_fail++; $display("FAIL b2b_first_done got=%0d exp=15", lat); end
    n_checks++;
    if (q !== 32'h40490FDB) begin n_fail++; $display("FAIL b2b_q got=%h exp=40490fdb", q); end
    // Start during PACK is ignored too.
    pos = 14'h0001; pp = 4'd3; start = 1'b1;
    @(posedge c); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle busy=%b done=%b exp busy=0 done=0", busy, done);
    end
    n_checks++;
    if (q !== 32'h40490FDB) begin n_fail++; $display("FAIL b2b_q_held got=%h exp=40490fdb", q); end
    launch(14'h0800, 14'h0000, 4'd7);
    wait_done(1, lat);
    n_checks++;
    if (lat != 15) begin n_fail++; $display("FAIL b2b_next_latency got=%0d exp=15", lat); end
    n_checks++;
    if (q !== 32'h40AFEDDF) begin n_fail++; $display("FAIL b2b_next_q got=%h exp=40afeddf", q); end
    @(posedge c); #1;
  endtask

  task automatic test_reset_abort;
    int lat;
    launch(14'h0001, 14'h0000, 4'd1);
    repeat (9) @(posedge c);
    #1;
    rst = 1'b1;
    @(posedge c); #1;
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_ctrl busy=%b done=%b exp busy=0 done=0", busy, done);
    end
    n_checks++;
    if (q !== 32'h0) begin n_fail++; $display("FAIL abort_q got=%h exp=00000000", q); end
    wait_done(0, lat);
    n_checks++;
    if (lat != -1) begin n_fail++; $display("FAIL abort_spurious_done got=%0d exp=-1", lat); end
    launch(14'h0001, 14'h0000, 4'd1);
    wait_done(1, lat);
    n_checks++;
    if (lat != 28) begin n_fail++; $display("FAIL lsb_latency got=%0d exp=28", lat); end
    // 2*pi/2^14 = 1.5708 * 2^-12 -> biased exponent 115.
    n_checks++;
    if (q !== 32'h39C90FDB) begin n_fail++; $display("FAIL lsb_q got=%h exp=39c90fdb", q); end
    @(posedge c); #1;
  endtask

  initial begin
    test_reset;
    test_pi;
    test_zero;
    test_wrap;
    test_pole_pairs;
    test_back_to_back;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
